// File: rtl/ctc_vec.sv
// Vectored Z80-style counter/timer: CHAN 8-bit down-counters with prescaled timer or
// external-edge counter modes, auto-reload, and mode-2 interrupts on an IEI/IEO daisy chain.

module ctc_vec_chan #(
    parameter int DWID   = 8,
    parameter int PRE_LO = 16,
    parameter int PRE_HI = 256
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            trig_i,
    input  logic            wr_i,
    input  logic [DWID-1:0] din_i,
    output logic [DWID-1:0] cnt_o,
    output logic            tc_next_o,
    output logic            int_en_o,
    output logic            zc_ev_o,
    output logic            zc_o,
    output logic            clr_o
);
    localparam int PMAX = (PRE_HI > PRE_LO) ? PRE_HI : PRE_LO;
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

    // Only the mode bits [7:3] are kept; bits 0..2 act at write time.
    logic [4:0]      mode_q;
    logic [DWID-1:0] tc_q, cnt_q;
    logic [PW-1:0]   pre_q, pre_lim;
    logic [2:0]      sync_q;
    logic            run_q, arm_q, tcn_q, zc_q;
    logic            wr_tc, wr_ccw, sw_rst, trig_edge, tick, dec, zc_ev;

    assign wr_tc     = wr_i & tcn_q;
    assign wr_ccw    = wr_i & ~tcn_q & din_i[0];
    assign sw_rst    = wr_ccw & din_i[1];
    assign trig_edge = mode_q[1] ? (sync_q[1] & ~sync_q[2]) : (~sync_q[1] & sync_q[2]);
    assign pre_lim   = mode_q[2] ? PW'(PRE_HI - 1) : PW'(PRE_LO - 1);
    assign tick      = mode_q[3] ? trig_edge : (pre_q >= pre_lim);
    // A software reset in the same cycle suppresses the decrement (and so the zero count).
    assign dec       = run_q & tick & ~sw_rst;
    assign zc_ev     = dec & (cnt_q == DWID'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q <= '0;
            tc_q   <= '0;
            cnt_q  <= '0;
            pre_q  <= '0;
            sync_q <= '0;
            run_q  <= 1'b0;
            arm_q  <= 1'b0;
            tcn_q  <= 1'b0;
            zc_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], trig_i};
            zc_q   <= zc_ev;
            if (wr_ccw) begin
                mode_q <= din_i[7:3];
                tcn_q  <= din_i[2];
            end
            if (wr_tc) begin
                tc_q  <= din_i;
                tcn_q <= 1'b0;
            end
            if (run_q && !mode_q[3])
                pre_q <= (pre_q >= pre_lim) ? '0 : pre_q + 1'b1;
            if (dec)
                cnt_q <= zc_ev ? tc_q : cnt_q - 1'b1;
            if (sw_rst) begin
                run_q <= 1'b0;
                arm_q <= 1'b0;
            end else if (wr_tc && !run_q) begin
                cnt_q <= din_i;
                pre_q <= '0;
                if (mode_q[3] || !mode_q[0]) run_q <= 1'b1;
                else                         arm_q <= 1'b1;
            end else if (arm_q && trig_edge) begin
                run_q <= 1'b1;
                arm_q <= 1'b0;
                pre_q <= '0;
            end
        end
    end

    assign cnt_o     = cnt_q;
    assign tc_next_o = tcn_q;
    assign int_en_o  = mode_q[4];
    assign zc_ev_o   = zc_ev;
    assign zc_o      = zc_q;
    assign clr_o     = sw_rst;
endmodule

module ctc_vec #(
    parameter int CHAN   = 4,
    parameter int AWID   = 2,
    parameter int DWID   = 8,
    parameter int PRE_LO = 16,
    parameter int PRE_HI = 256
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ce_n,
    input  logic            m1_n,
    input  logic            rd_n,
    input  logic            iorq_n,
    input  logic [AWID-1:0] a,
    input  logic [DWID-1:0] din,
    output logic [DWID-1:0] dout,
    output logic            oe_n,
    input  logic            iei,
    output logic            ieo,
    output logic            int_n,
    input  logic            reti,
    input  logic [CHAN-1:0] clk_trig,
    output logic [CHAN-1:0] zc_to
);
    logic            wr_q, wr_qq, rd_q, rd_qq, ack_q, ack_qq;
    logic [AWID-1:0] a_q;
    logic [DWID-1:0] din_q, dout_q, dout_d, rd_val;
    logic [DWID-AWID-2:0] base_q;
    logic            oe_n_q, oe_n_d, int_n_q;
    logic            wr_stb, rd_stb, ack_ok;
    logic [CHAN-1:0] pend_q, pend_d, isv_q, isv_d, pend_lo, isv_lo;
    logic [CHAN-1:0] wr_ch, tcn, int_en, zc_ev, clr;
    logic [CHAN-1:0][DWID-1:0] cnt;
    logic [AWID-1:0] hi_idx;

    // Strobes act one clock after the bus condition is first sampled, once per assertion.
    assign wr_stb = wr_q & ~wr_qq;
    assign rd_stb = rd_q & ~rd_qq;
    assign ack_ok = ack_q & ~ack_qq & ~int_n_q & (|pend_q);

    for (genvar i = 0; i < CHAN; i++) begin : g_ch
        assign wr_ch[i] = wr_stb && (a_q == AWID'(i));
        ctc_vec_chan #(.DWID(DWID), .PRE_LO(PRE_LO), .PRE_HI(PRE_HI)) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .trig_i    (clk_trig[i]),
            .wr_i      (wr_ch[i]),
            .din_i     (din_q),
            .cnt_o     (cnt[i]),
            .tc_next_o (tcn[i]),
            .int_en_o  (int_en[i]),
            .zc_ev_o   (zc_ev[i]),
            .zc_o      (zc_to[i]),
            .clr_o     (clr[i])
        );
    end

    // Lowest index wins: isolate the least-significant set bit.
    assign pend_lo = pend_q & (~pend_q + 1'b1);
    assign isv_lo  = isv_q & (~isv_q + 1'b1);

    always_comb begin
        hi_idx = '0;
        for (int i = CHAN - 1; i >= 0; i--)
            if (pend_q[i]) hi_idx = AWID'(i);
        rd_val = '0;
        for (int i = 0; i < CHAN; i++)
            if (a_q == AWID'(i)) rd_val = cnt[i];
    end

    always_comb begin
        pend_d = ((pend_q & ~(ack_ok ? pend_lo : '0)) | (zc_ev & int_en)) & ~clr;
        isv_d  = (isv_q & ~((reti && iei) ? isv_lo : '0)) | (ack_ok ? pend_lo : '0);
        dout_d = '0;
        oe_n_d = 1'b1;
        if (rd_stb) begin
            dout_d = rd_val;
            oe_n_d = 1'b0;
        end else if (ack_ok) begin
            dout_d = {base_q, hi_idx, 1'b0};
            oe_n_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= 1'b0;
            wr_qq   <= 1'b0;
            rd_q    <= 1'b0;
            rd_qq   <= 1'b0;
            ack_q   <= 1'b0;
            ack_qq  <= 1'b0;
            a_q     <= '0;
            din_q   <= '0;
            base_q  <= '0;
            pend_q  <= '0;
            isv_q   <= '0;
            dout_q  <= '0;
            oe_n_q  <= 1'b1;
            int_n_q <= 1'b1;
        end else begin
            wr_q    <= ~ce_n & ~iorq_n & m1_n & rd_n;
            rd_q    <= ~ce_n & ~iorq_n & m1_n & ~rd_n;
            ack_q   <= ~m1_n & ~iorq_n;
            wr_qq   <= wr_q;
            rd_qq   <= rd_q;
            ack_qq  <= ack_q;
            a_q     <= a;
            din_q   <= din;
            if (wr_stb && a_q == '0 && !tcn[0] && !din_q[0])
                base_q <= din_q[DWID-1:AWID+1];
            pend_q  <= pend_d;
            isv_q   <= isv_d;
            dout_q  <= dout_d;
            oe_n_q  <= oe_n_d;
            int_n_q <= ~(iei & (|pend_q) & ~(|isv_q));
        end
    end

    assign dout  = dout_q;
    assign oe_n  = oe_n_q;
    assign int_n = int_n_q;
    assign ieo   = iei & ~(|pend_q) & ~(|isv_q);
endmodule

// File: tb/tb_ctc_vec.sv
// Directed bench for ctc_vec: bus writes/reads, timer and counter periods, vectored
// interrupt acknowledge, daisy-chain gating, software stop and asynchronous reset.

module tb_ctc_vec;
    logic       clk = 1'b0, reset_n = 1'b0;
    logic       ce_n = 1'b1, m1_n = 1'b1, rd_n = 1'b1, iorq_n = 1'b1;
    logic [1:0] a = '0;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic       oe_n, iei = 1'b1, ieo, int_n, reti = 1'b0;
    logic [3:0] clk_trig = '0, zc_to;
    int         nvec = 0, nerr = 0;
    int         zc_cnt [4] = '{0, 0, 0, 0};

    ctc_vec #(.CHAN(4), .AWID(2), .DWID(8), .PRE_LO(16), .PRE_HI(256)) dut (
        .clk(clk), .reset_n(reset_n), .ce_n(ce_n), .m1_n(m1_n), .rd_n(rd_n), .iorq_n(iorq_n),
        .a(a), .din(din), .dout(dout), .oe_n(oe_n), .iei(iei), .ieo(ieo), .int_n(int_n),
        .reti(reti), .clk_trig(clk_trig), .zc_to(zc_to)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        for (int i = 0; i < 4; i++) if (zc_to[i] === 1'b1) zc_cnt[i]++;

    // All bus tasks are entered and left at a falling edge.
    task automatic bus_wr(input logic [1:0] ch, input logic [7:0] d);
        a = ch; din = d; ce_n = 1'b0; iorq_n = 1'b0;
        repeat (2) @(negedge clk);
        ce_n = 1'b1; iorq_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic bus_rd(input logic [1:0] ch, output logic [7:0] v, output int n);
        v = '0; n = 0; a = ch; ce_n = 1'b0; iorq_n = 1'b0; rd_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (oe_n === 1'b0) begin n++; v = dout; end
            if (i == 1) begin ce_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; end
        end
    endtask

    task automatic bus_ack(output logic [7:0] v, output int n);
        v = '0; n = 0; m1_n = 1'b0; iorq_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (oe_n === 1'b0) begin n++; v = dout; end
            if (i == 1) begin m1_n = 1'b1; iorq_n = 1'b1; end
        end
    endtask

    task automatic pulse(input int ch);
        clk_trig[ch] = 1'b1;
        repeat (4) @(negedge clk);
        clk_trig[ch] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reti();
        reti = 1'b1;
        @(negedge clk);
        reti = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_zc(input int ch, input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (zc_to[ch] !== 1'b1 && n < bound);
    endtask

    task automatic test_reset();
        logic [7:0] v; int n;
        repeat (3) @(negedge clk);
        nvec++; if ({dout, oe_n, int_n, zc_to, ieo} !== {8'h00, 1'b1, 1'b1, 4'h0, 1'b1}) begin
            nerr++; $display("FAIL reset_outputs: got dout=%h oe_n=%b int_n=%b zc=%b ieo=%b", dout, oe_n, int_n, zc_to, ieo);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        bus_rd(2'd1, v, n);
        nvec++; if (v !== 8'h00 || n !== 1) begin
            nerr++; $display("FAIL reset_count: got %h (oe %0d clk), want 00 (1 clk)", v, n);
        end
    endtask

    task automatic test_timer();
        logic [7:0] v; int n;
        bus_wr(2'd0, 8'h05);
        bus_wr(2'd0, 8'h03);
        wait_zc(0, 200, n);
        nvec++; if (n >= 200) begin nerr++; $display("FAIL timer_first_zc: no pulse in %0d clk", n); end
        wait_zc(0, 200, n);
        nvec++; if (n !== 48) begin nerr++; $display("FAIL timer_period: got %0d clk, want 48", n); end
        bus_rd(2'd0, v, n);
        nvec++; if (v !== 8'h03 || n !== 1) begin
            nerr++; $display("FAIL timer_reload: got %h (oe %0d clk), want 03 (1 clk)", v, n);
        end
        bus_wr(2'd0, 8'h03);
    endtask

    task automatic test_counter();
        int c0;
        bus_wr(2'd1, 8'hC7);
        bus_wr(2'd1, 8'h02);
        c0 = zc_cnt[1];
        pulse(1);
        nvec++; if (zc_cnt[1] !== c0) begin nerr++; $display("FAIL counter_one_edge: zc count %0d, want %0d", zc_cnt[1], c0); end
        pulse(1);
        nvec++; if (zc_cnt[1] !== c0 + 1) begin nerr++; $display("FAIL counter_two_edges: zc count %0d, want %0d", zc_cnt[1], c0 + 1); end
        repeat (2) @(negedge clk);
        nvec++; if (int_n !== 1'b0 || ieo !== 1'b0) begin
            nerr++; $display("FAIL counter_int: got int_n=%b ieo=%b, want 0 0", int_n, ieo);
        end
    endtask

    task automatic test_vector();
        logic [7:0] v; int n;
        bus_wr(2'd0, 8'h40);
        bus_wr(2'd2, 8'hC7);
        bus_wr(2'd2, 8'h01);
        pulse(2);
        repeat (2) @(negedge clk);
        bus_ack(v, n);
        nvec++; if (v !== 8'h42 || n !== 1) begin nerr++; $display("FAIL ack_ch1: got %h (oe %0d clk), want 42 (1 clk)", v, n); end
        nvec++; if (int_n !== 1'b1) begin nerr++; $display("FAIL in_service_mask: int_n=%b, want 1", int_n); end
        do_reti();
        nvec++; if (int_n !== 1'b0) begin nerr++; $display("FAIL reti_reenable: int_n=%b, want 0", int_n); end
        bus_ack(v, n);
        nvec++; if (v !== 8'h44 || n !== 1) begin nerr++; $display("FAIL ack_ch2: got %h (oe %0d clk), want 44 (1 clk)", v, n); end
    endtask

    task automatic test_iei();
        logic [7:0] v; int n;
        pulse(2);
        iei = 1'b0;
        repeat (3) @(negedge clk);
        nvec++; if (int_n !== 1'b1 || ieo !== 1'b0) begin
            nerr++; $display("FAIL iei_low: got int_n=%b ieo=%b, want 1 0", int_n, ieo);
        end
        bus_ack(v, n);
        nvec++; if (n !== 0) begin nerr++; $display("FAIL iei_low_ack: oe_n low %0d clk, want 0", n); end
        do_reti();
        iei = 1'b1;
        repeat (3) @(negedge clk);
        nvec++; if (int_n !== 1'b1) begin nerr++; $display("FAIL reti_ignored: int_n=%b, want 1", int_n); end
        do_reti();
        nvec++; if (int_n !== 1'b0) begin nerr++; $display("FAIL reti_clears: int_n=%b, want 0", int_n); end
        bus_ack(v, n);
        nvec++; if (v !== 8'h44 || n !== 1) begin nerr++; $display("FAIL ack_ch2_again: got %h (oe %0d clk), want 44", v, n); end
        do_reti();
        bus_wr(2'd1, 8'h03);
        bus_wr(2'd2, 8'h03);
        repeat (3) @(negedge clk);
        nvec++; if (int_n !== 1'b1 || ieo !== 1'b1) begin
            nerr++; $display("FAIL chain_idle: got int_n=%b ieo=%b, want 1 1", int_n, ieo);
        end
    endtask

    task automatic test_trigger();
        logic [7:0] r1, r2, v; int n, c0;
        bus_wr(2'd2, 8'h0D);
        bus_wr(2'd2, 8'h00);
        c0 = zc_cnt[2];
        repeat (50) @(negedge clk);
        bus_rd(2'd2, v, n);
        nvec++; if (v !== 8'h00 || zc_cnt[2] !== c0) begin
            nerr++; $display("FAIL trig_armed: count %h zc %0d, want 00 %0d", v, zc_cnt[2], c0);
        end
        pulse(2);
        repeat (100) @(negedge clk);
        bus_rd(2'd2, r1, n);
        repeat (64) @(negedge clk);
        bus_rd(2'd2, r2, n);
        nvec++; if (r1 < 8'd245 || r1 > 8'd252) begin nerr++; $display("FAIL trig_read1: got %0d, want 245..252", r1); end
        nvec++; if (r1 - r2 < 3 || r1 - r2 > 5) begin nerr++; $display("FAIL trig_read2: got %0d after %0d, want 3..5 less", r2, r1); end
        wait_zc(2, 5000, n);
        nvec++; if (n >= 5000) begin nerr++; $display("FAIL trig_first_zc: none in %0d clk", n); end
        wait_zc(2, 5000, n);
        nvec++; if (n !== 4096) begin nerr++; $display("FAIL trig_period: got %0d clk, want 4096", n); end
    endtask

    task automatic test_stop();
        logic [7:0] r1, r2; int n, c0;
        bus_wr(2'd3, 8'h85);
        bus_wr(2'd3, 8'h02);
        wait_zc(3, 100, n);
        nvec++; if (n >= 100) begin nerr++; $display("FAIL ch3_zc: none in %0d clk", n); end
        repeat (2) @(negedge clk);
        nvec++; if (int_n !== 1'b0) begin nerr++; $display("FAIL ch3_int: int_n=%b, want 0", int_n); end
        bus_wr(2'd3, 8'h03);
        repeat (2) @(negedge clk);
        nvec++; if (int_n !== 1'b1) begin nerr++; $display("FAIL stop_clears_pending: int_n=%b, want 1", int_n); end
        c0 = zc_cnt[3];
        bus_rd(2'd3, r1, n);
        repeat (80) @(negedge clk);
        bus_rd(2'd3, r2, n);
        nvec++; if (r2 !== r1 || zc_cnt[3] !== c0) begin
            nerr++; $display("FAIL stop_holds: count %h->%h zc %0d->%0d, want held", r1, r2, c0, zc_cnt[3]);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v; int n, c2, c3;
        bus_wr(2'd3, 8'h85);
        bus_wr(2'd3, 8'h02);
        repeat (40) @(negedge clk);
        reset_n = 1'b0;
        #1;
        nvec++; if ({dout, oe_n, int_n, zc_to, ieo} !== {8'h00, 1'b1, 1'b1, 4'h0, 1'b1}) begin
            nerr++; $display("FAIL reset_mid: got dout=%h oe_n=%b int_n=%b zc=%b ieo=%b", dout, oe_n, int_n, zc_to, ieo);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        c2 = zc_cnt[2]; c3 = zc_cnt[3];
        repeat (300) @(negedge clk);
        bus_rd(2'd2, v, n);
        nvec++; if (v !== 8'h00 || zc_cnt[2] !== c2 || zc_cnt[3] !== c3) begin
            nerr++; $display("FAIL reset_mid_stopped: count %h zc2 %0d zc3 %0d, want 00 %0d %0d", v, zc_cnt[2], zc_cnt[3], c2, c3);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_timer();
        test_counter();
        test_vector();
        test_iei();
        test_trigger();
        test_stop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
